dco_sar_tuner: RTL



---
 rtl/dco_sar_tuner_if.sv | 29 ++
 rtl/dco_sar_tuner.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dco_sar_tuner_if.sv
`default_nettype none
// ==========================================================================
// dco_sar_tuner_if : control/DCO bundle for the SAR coarse tuner. rev 1.0
// ==========================================================================
interface dco_sar_tuner_if #(
  parameter int BITLEN = 16,
  parameter int CNT_W  = 16
) ();
  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  target_cnt;
  logic              dco_tick;
  logic [BITLEN-1:0] d_out;
  logic              dco_enable;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  meas_cnt;

  modport master (
    output start, abort, target_cnt, dco_tick,
    input  d_out, dco_enable, busy, done, meas_cnt
  );

  modport slave (
    input  start, abort, target_cnt, dco_tick,
    output d_out, dco_enable, busy, done, meas_cnt
  );
endinterface
`default_nettype wire

// File: rtl/dco_sar_tuner.sv
`default_nettype none
// ==========================================================================
// dco_sar_tuner : SAR search of the DCO code against a per-window edge count. rev 1.0
// ==========================================================================
module dco_sar_tuner #(
  parameter int BITLEN     = 16,
  parameter int CNT_W      = 16,
  parameter int WIN_CYC    = 256,
  parameter int SETTLE_CYC = 16
) (
  input  wire logic        clk,
  input  wire logic        n_rst,
  dco_sar_tuner_if.slave   bus
);

  localparam int c_TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
  localparam int c_IDX_W   = (BITLEN > 1) ? $clog2(BITLEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_DECIDE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [BITLEN-1:0]   d_out_q, d_out_d;
  logic                en_q, en_d;
  logic [c_IDX_W-1:0]  idx_q, idx_d;
  logic [c_TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]    edge_q, edge_d;
  logic [CNT_W-1:0]    meas_q, meas_d;

  logic [BITLEN-1:0]   w_bit;
  logic [BITLEN-1:0]   w_res;

  // d_out_q always holds the current trial, so the kept result is the trial
  // with the bit under test dropped when the DCO ran too fast.
  assign w_bit = BITLEN'(1) << idx_q;
  assign w_res = (edge_q > bus.target_cnt) ? (d_out_q & ~w_bit) : d_out_q;

  always_comb begin
    state_d = state_q;
    d_out_d = d_out_q;
    en_d    = en_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    edge_d  = edge_q;
    meas_d  = meas_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SETTLE;
          d_out_d = BITLEN'(1) << (BITLEN - 1);
          en_d    = 1'b1;
          idx_d   = c_IDX_W'(BITLEN - 1);
          tmr_d   = c_TMR_W'(SETTLE_CYC);
        end
      end
      S_SETTLE: begin
        tmr_d = tmr_q - c_TMR_W'(1);
        if (tmr_q == c_TMR_W'(1)) begin
          state_d = S_MEASURE;
          tmr_d   = c_TMR_W'(WIN_CYC);
          edge_d  = '0;
        end
      end
      S_MEASURE: begin
        if (bus.dco_tick && (edge_q != {CNT_W{1'b1}})) begin
          edge_d = edge_q + CNT_W'(1);
        end
        tmr_d = tmr_q - c_TMR_W'(1);
        if (tmr_q == c_TMR_W'(1)) begin
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        meas_d = edge_q;
        if (idx_q == '0) begin
          state_d = S_DONE;
          d_out_d = w_res;
        end else begin
          state_d = S_SETTLE;
          idx_d   = idx_q - c_IDX_W'(1);
          d_out_d = w_res | (w_bit >> 1);
          tmr_d   = c_TMR_W'(SETTLE_CYC);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything except reset; the debug count survives.
    if (bus.abort) begin
      state_d = S_IDLE;
      d_out_d = '0;
      en_d    = 1'b0;
      idx_d   = '0;
      tmr_d   = '0;
      edge_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      d_out_q <= '0;
      en_q    <= 1'b0;
      idx_q   <= '0;
      tmr_q   <= '0;
      edge_q  <= '0;
      meas_q  <= '0;
    end else begin
      state_q <= state_d;
      d_out_q <= d_out_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      edge_q  <= edge_d;
      meas_q  <= meas_d;
    end
  end

  assign bus.d_out      = d_out_q;
  assign bus.dco_enable = en_q;
  assign bus.busy       = (state_q == S_SETTLE) || (state_q == S_MEASURE) ||
                          (state_q == S_DECIDE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.meas_cnt   = meas_q;

endmodule
`default_nettype wire
